// File: rtl/johnson_seq_checker_if.sv
// Johnson checker bus: upstream sample/controls in,
// decoded phase, lock status and counters out.
interface johnson_seq_checker_if #(
  parameter int ERR_W = 8,
  parameter int CYC_W = 8
);
  logic [3:0]       count_in;
  logic             en;
  logic             err_clr;
  logic [2:0]       phase;
  logic [7:0]       phase_onehot;
  logic             valid;
  logic             locked;
  logic             seq_err;
  logic [ERR_W-1:0] err_cnt;
  logic             wrap;
  logic [CYC_W-1:0] cycle_cnt;

  modport master (
    output count_in, en, err_clr,
    input  phase, phase_onehot, valid, locked,
    input  seq_err, err_cnt, wrap, cycle_cnt
  );

  modport slave (
    input  count_in, en, err_clr,
    output phase, phase_onehot, valid, locked,
    output seq_err, err_cnt, wrap, cycle_cnt
  );
endinterface

// File: rtl/johnson_seq_checker.sv
// Johnson code decoder and sequence checker:
// phase decode, lock FSM, error and cycle counters.
module johnson_seq_checker #(
  parameter int LOCK_N     = 3,
  parameter bit ALLOW_HOLD = 1'b0,
  parameter int ERR_W      = 8,
  parameter int CYC_W      = 8
) (
  input  logic                 clk,
  input  logic                 clear,
  johnson_seq_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_UNLOCKED,
    S_ACQUIRE,
    S_LOCKED
  } state_e;

  localparam logic [3:0] LOCK_4 = 4'(LOCK_N);

  state_e           state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic [2:0]       phase_q, phase_d;
  logic [7:0]       onehot_q, onehot_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             seq_err_q, seq_err_d;
  logic             wrap_q, wrap_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [CYC_W-1:0] cycle_cnt_q, cycle_cnt_d;

  logic       legal;
  logic [2:0] cur;
  logic [2:0] nxt;
  logic [3:0] run_inc;
  logic       good;
  logic       hold;
  logic       step_wrap;
  logic       err_inc;

  // Map the incoming code onto its phase index.
  always_comb begin
    cur   = 3'd0;
    legal = 1'b1;
    unique case (bus.count_in)
      4'b0000: cur = 3'd0;
      4'b1000: cur = 3'd1;
      4'b1100: cur = 3'd2;
      4'b1110: cur = 3'd3;
      4'b1111: cur = 3'd4;
      4'b0111: cur = 3'd5;
      4'b0011: cur = 3'd6;
      4'b0001: cur = 3'd7;
      default: legal = 1'b0;
    endcase
  end

  // phase_q always holds the last legal sample, so it
  // doubles as the previous-phase anchor.
  assign nxt       = phase_q + 3'd1;
  assign run_inc   = run_q + 4'd1;
  assign good      = legal && (cur == nxt);
  assign hold      = ALLOW_HOLD && legal && (cur == phase_q);
  assign step_wrap = (phase_q == 3'd7);

  // Next-state: step classification, lock FSM and counters.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    phase_d     = phase_q;
    valid_d     = valid_q;
    seq_err_d   = 1'b0;
    wrap_d      = 1'b0;
    err_inc     = 1'b0;
    if (bus.en) begin
      valid_d = legal;
      if (legal) phase_d = cur;
      case (state_q)
        S_UNLOCKED: begin
          if (legal) begin
            state_d = S_ACQUIRE;
            run_d   = 4'd0;
          end
        end
        S_ACQUIRE: begin
          unique case (1'b1)
            good: begin
              run_d = run_inc;
              if (run_inc == LOCK_4) begin
                state_d = S_LOCKED;
                wrap_d  = step_wrap;
              end
            end
            hold: begin
            end
            default: begin
              run_d   = 4'd0;
              state_d = legal ? S_ACQUIRE : S_UNLOCKED;
            end
          endcase
        end
        S_LOCKED: begin
          unique case (1'b1)
            good: wrap_d = step_wrap;
            hold: begin
            end
            default: begin
              seq_err_d = 1'b1;
              err_inc   = 1'b1;
              run_d     = 4'd0;
              state_d   = legal ? S_ACQUIRE : S_UNLOCKED;
            end
          endcase
        end
        default: begin
          state_d = S_UNLOCKED;
          run_d   = 4'd0;
        end
      endcase
    end

    onehot_d = valid_d ? (8'd1 << phase_d) : 8'd0;
    locked_d = (state_d == S_LOCKED);

    err_cnt_d = err_cnt_q;
    if (bus.err_clr)
      err_cnt_d = '0;
    else if (err_inc && (err_cnt_q != {ERR_W{1'b1}}))
      err_cnt_d = err_cnt_q + 1'b1;

    cycle_cnt_d = cycle_cnt_q;
    if (wrap_d)
      cycle_cnt_d = cycle_cnt_q + 1'b1;
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q     <= S_UNLOCKED;
      run_q       <= 4'd0;
      phase_q     <= 3'd0;
      onehot_q    <= 8'd0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      seq_err_q   <= 1'b0;
      wrap_q      <= 1'b0;
      err_cnt_q   <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      phase_q     <= phase_d;
      onehot_q    <= onehot_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      seq_err_q   <= seq_err_d;
      wrap_q      <= wrap_d;
      err_cnt_q   <= err_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign bus.phase        = phase_q;
  assign bus.phase_onehot = onehot_q;
  assign bus.valid        = valid_q;
  assign bus.locked       = locked_q;
  assign bus.seq_err      = seq_err_q;
  assign bus.wrap         = wrap_q;
  assign bus.err_cnt      = err_cnt_q;
  assign bus.cycle_cnt    = cycle_cnt_q;

endmodule

// File: tb/tb_johnson_seq_checker.sv
// Bench for johnson_seq_checker: vector table, corner
// sequences and random stimulus against a phase model.
module tb_johnson_seq_checker;

  logic clk;
  logic clear;

  johnson_seq_checker_if #(.ERR_W(8), .CYC_W(8)) i0 ();
  johnson_seq_checker_if #(.ERR_W(8), .CYC_W(8)) i1 ();
  johnson_seq_checker_if #(.ERR_W(2), .CYC_W(8)) i2 ();
  johnson_seq_checker_if #(.ERR_W(8), .CYC_W(2)) i3 ();

  johnson_seq_checker #(
    .LOCK_N(3), .ALLOW_HOLD(1'b0), .ERR_W(8), .CYC_W(8)
  ) u0 (.clk(clk), .clear(clear), .bus(i0));

  johnson_seq_checker #(
    .LOCK_N(3), .ALLOW_HOLD(1'b1), .ERR_W(8), .CYC_W(8)
  ) u1 (.clk(clk), .clear(clear), .bus(i1));

  johnson_seq_checker #(
    .LOCK_N(3), .ALLOW_HOLD(1'b0), .ERR_W(2), .CYC_W(8)
  ) u2 (.clk(clk), .clear(clear), .bus(i2));

  johnson_seq_checker #(
    .LOCK_N(1), .ALLOW_HOLD(1'b0), .ERR_W(8), .CYC_W(2)
  ) u3 (.clk(clk), .clear(clear), .bus(i3));

  localparam logic [3:0] JCODE [8] = '{
    4'b0000, 4'b1000, 4'b1100, 4'b1110,
    4'b1111, 4'b0111, 4'b0011, 4'b0001
  };
  localparam logic [3:0] ILL [8] = '{
    4'b0010, 4'b0100, 4'b0101, 4'b0110,
    4'b1001, 4'b1010, 4'b1011, 4'b1101
  };
  localparam int P_LOCK [4] = '{3, 3, 3, 1};
  localparam int P_HOLD [4] = '{0, 1, 0, 0};
  localparam int P_EMAX [4] = '{255, 255, 3, 255};
  localparam int P_CMOD [4] = '{256, 256, 256, 4};

  // mode: 0 unlocked, 1 acquiring, 2 locked
  typedef struct packed {
    int mode;
    int run;
    int phase;
    int valid;
    int serr;
    int wrp;
    int err;
    int cyc;
  } mdl_t;

  typedef struct packed {
    int c;
    int e;
    int ec;
    int code;
    int ph;
    int oh;
    int vl;
    int lk;
    int se;
    int wr;
    int er;
    int cy;
  } vec_t;

  mdl_t m [4];
  vec_t tbl [32];
  int   n_cmp;
  int   n_bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int idx_of(logic [3:0] c);
    for (int i = 0; i < 8; i++)
      if (JCODE[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [3:0] code_of(int i);
    return JCODE[i % 8];
  endfunction

  function automatic mdl_t mstep(mdl_t o, int c, int e,
                                 int ec, logic [3:0] code,
                                 int k);
    mdl_t n;
    int   idx;
    bit   good;
    bit   hold;
    bit   inc;
    n = '0;
    if (c == 0) return n;
    n     = o;
    n.serr = 0;
    n.wrp  = 0;
    inc    = 0;
    if (e != 0) begin
      idx     = idx_of(code);
      n.valid = (idx >= 0) ? 1 : 0;
      if (idx >= 0) n.phase = idx;
      good = (idx >= 0) && (idx == (o.phase + 1) % 8);
      hold = (P_HOLD[k] != 0) && (idx == o.phase);
      if (o.mode == 0) begin
        if (idx >= 0) begin
          n.mode = 1;
          n.run  = 0;
        end
      end else if (good) begin
        if (o.mode == 1) begin
          n.run = o.run + 1;
          if (n.run == P_LOCK[k]) n.mode = 2;
        end
        if (n.mode == 2 && o.phase == 7) begin
          n.wrp = 1;
          n.cyc = (o.cyc + 1) % P_CMOD[k];
        end
      end else if (!hold) begin
        if (o.mode == 2) begin
          n.serr = 1;
          inc    = 1;
        end
        n.mode = (idx >= 0) ? 1 : 0;
        n.run  = 0;
      end
    end
    if (ec != 0) n.err = 0;
    else if (inc && o.err < P_EMAX[k]) n.err = o.err + 1;
    return n;
  endfunction

  function automatic vec_t v(int c, int e, int ec, int code,
                             int ph, int oh, int vl, int lk,
                             int se, int wr, int er, int cy);
    vec_t r;
    r = '{c, e, ec, code, ph, oh, vl, lk, se, wr, er, cy};
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_dut(int k, logic [2:0] ph,
                         logic [7:0] oh, logic vl,
                         logic lk, logic se, logic wr,
                         logic [31:0] er, logic [31:0] cy);
    string p;
    int    eoh;
    p   = $sformatf("d%0d.", k);
    eoh = (m[k].valid != 0) ? (1 << m[k].phase) : 0;
    chk({p, "phase"}, 32'(ph), m[k].phase);
    chk({p, "onehot"}, 32'(oh), eoh);
    chk({p, "valid"}, 32'(vl), m[k].valid);
    chk({p, "locked"}, 32'(lk), (m[k].mode == 2) ? 1 : 0);
    chk({p, "seq_err"}, 32'(se), m[k].serr);
    chk({p, "wrap"}, 32'(wr), m[k].wrp);
    chk({p, "err_cnt"}, er, m[k].err);
    chk({p, "cycle_cnt"}, cy, m[k].cyc);
  endtask

  task automatic chk_all();
    chk_dut(0, i0.phase, i0.phase_onehot, i0.valid,
            i0.locked, i0.seq_err, i0.wrap,
            32'(i0.err_cnt), 32'(i0.cycle_cnt));
    chk_dut(1, i1.phase, i1.phase_onehot, i1.valid,
            i1.locked, i1.seq_err, i1.wrap,
            32'(i1.err_cnt), 32'(i1.cycle_cnt));
    chk_dut(2, i2.phase, i2.phase_onehot, i2.valid,
            i2.locked, i2.seq_err, i2.wrap,
            32'(i2.err_cnt), 32'(i2.cycle_cnt));
    chk_dut(3, i3.phase, i3.phase_onehot, i3.valid,
            i3.locked, i3.seq_err, i3.wrap,
            32'(i3.err_cnt), 32'(i3.cycle_cnt));
  endtask

  // One sampled edge: drive, clock, advance models, compare.
  task automatic step(int c, int e, int ec, logic [3:0] code);
    clear       = (c != 0);
    i0.count_in = code;
    i1.count_in = code;
    i2.count_in = code;
    i3.count_in = code;
    i0.en = (e != 0); i1.en = (e != 0);
    i2.en = (e != 0); i3.en = (e != 0);
    i0.err_clr = (ec != 0); i1.err_clr = (ec != 0);
    i2.err_clr = (ec != 0); i3.err_clr = (ec != 0);
    @(posedge clk);
    for (int k = 0; k < 4; k++)
      m[k] = mstep(m[k], c, e, ec, code, k);
    #1;
    chk_all();
  endtask

  task automatic go(int idx);
    step(1, 1, 0, code_of(idx));
  endtask

  initial begin
    int cur;
    int sel;
    int c;
    int e;
    int ec;
    logic [3:0] code;
    string t;

    n_cmp = 0;
    n_bad = 0;
    for (int k = 0; k < 4; k++) m[k] = '0;

    tbl[0]  = v(0,1,0,'b0000, 0,'h00,0,0,0,0,0,0);
    tbl[1]  = v(1,1,0,'b0000, 0,'h01,1,0,0,0,0,0);
    tbl[2]  = v(1,1,0,'b1000, 1,'h02,1,0,0,0,0,0);
    tbl[3]  = v(1,1,0,'b1100, 2,'h04,1,0,0,0,0,0);
    tbl[4]  = v(1,1,0,'b1110, 3,'h08,1,1,0,0,0,0);
    tbl[5]  = v(1,1,0,'b1111, 4,'h10,1,1,0,0,0,0);
    tbl[6]  = v(1,1,0,'b0111, 5,'h20,1,1,0,0,0,0);
    tbl[7]  = v(1,1,0,'b0011, 6,'h40,1,1,0,0,0,0);
    tbl[8]  = v(1,1,0,'b0001, 7,'h80,1,1,0,0,0,0);
    tbl[9]  = v(1,1,0,'b0000, 0,'h01,1,1,0,1,0,1);
    tbl[10] = v(1,1,0,'b1000, 1,'h02,1,1,0,0,0,1);
    tbl[11] = v(1,1,0,'b1100, 2,'h04,1,1,0,0,0,1);
    tbl[12] = v(1,1,0,'b1111, 4,'h10,1,0,1,0,1,1);
    tbl[13] = v(1,1,0,'b0111, 5,'h20,1,0,0,0,1,1);
    tbl[14] = v(1,1,0,'b0011, 6,'h40,1,0,0,0,1,1);
    tbl[15] = v(1,1,0,'b0001, 7,'h80,1,1,0,0,1,1);
    tbl[16] = v(1,1,0,'b0000, 0,'h01,1,1,0,1,1,2);
    tbl[17] = v(1,1,0,'b1000, 1,'h02,1,1,0,0,1,2);
    tbl[18] = v(1,1,0,'b1100, 2,'h04,1,1,0,0,1,2);
    tbl[19] = v(1,1,0,'b1010, 2,'h00,0,0,1,0,2,2);
    tbl[20] = v(1,1,0,'b0000, 0,'h01,1,0,0,0,2,2);
    tbl[21] = v(1,1,0,'b1000, 1,'h02,1,0,0,0,2,2);
    tbl[22] = v(1,1,0,'b1100, 2,'h04,1,0,0,0,2,2);
    tbl[23] = v(1,1,0,'b1110, 3,'h08,1,1,0,0,2,2);
    tbl[24] = v(1,1,0,'b1110, 3,'h08,1,0,1,0,3,2);
    tbl[25] = v(1,0,0,'b1010, 3,'h08,1,0,0,0,3,2);
    tbl[26] = v(1,0,1,'b0101, 3,'h08,1,0,0,0,0,2);
    tbl[27] = v(1,1,0,'b1111, 4,'h10,1,0,0,0,0,2);
    tbl[28] = v(1,1,0,'b0111, 5,'h20,1,0,0,0,0,2);
    tbl[29] = v(1,1,0,'b0011, 6,'h40,1,1,0,0,0,2);
    tbl[30] = v(1,1,1,'b0000, 0,'h01,1,0,1,0,0,2);
    tbl[31] = v(0,1,0,'b1000, 0,'h00,0,0,0,0,0,0);

    for (int i = 0; i < 32; i++) begin
      step(tbl[i].c, tbl[i].e, tbl[i].ec, 4'(tbl[i].code));
      t = $sformatf("t%0d.", i);
      chk({t, "phase"}, 32'(i0.phase), tbl[i].ph);
      chk({t, "onehot"}, 32'(i0.phase_onehot), tbl[i].oh);
      chk({t, "valid"}, 32'(i0.valid), tbl[i].vl);
      chk({t, "locked"}, 32'(i0.locked), tbl[i].lk);
      chk({t, "seq_err"}, 32'(i0.seq_err), tbl[i].se);
      chk({t, "wrap"}, 32'(i0.wrap), tbl[i].wr);
      chk({t, "err_cnt"}, 32'(i0.err_cnt), tbl[i].er);
      chk({t, "cycle_cnt"}, 32'(i0.cycle_cnt), tbl[i].cy);
      if (i == 24) begin
        chk("hold.locked", 32'(i1.locked), 1);
        chk("hold.err_cnt", 32'(i1.err_cnt), 2);
        chk("hold.seq_err", 32'(i1.seq_err), 0);
      end
    end

    // Saturation and clear-over-increment.
    for (int i = 0; i < 4; i++) go(i);
    cur = 3;
    for (int k = 0; k < 5; k++) begin
      cur = (cur + 2) % 8;
      go(cur);
      for (int j = 0; j < 3; j++) begin
        cur = (cur + 1) % 8;
        go(cur);
      end
    end
    chk("sat.d0_err", 32'(i0.err_cnt), 5);
    chk("sat.d2_err", 32'(i2.err_cnt), 3);
    cur = (cur + 2) % 8;
    step(1, 1, 1, code_of(cur));
    chk("clrpri.seq_err", 32'(i0.seq_err), 1);
    chk("clrpri.d0_err", 32'(i0.err_cnt), 0);
    chk("clrpri.d2_err", 32'(i2.err_cnt), 0);

    // LOCK_N=1 boundary, then reset mid-run.
    step(0, 1, 0, 4'b0000);
    go(0);
    go(1);
    chk("lock1.d3_locked", 32'(i3.locked), 1);
    chk("lock1.d0_locked", 32'(i0.locked), 0);
    cur = 1;
    for (int i = 0; i < 39; i++) begin
      cur = (cur + 1) % 8;
      go(cur);
    end
    go(2); go(3); go(4); go(5);
    go(7); go(0); go(1); go(2);
    chk("mid.cyc", 32'(i0.cycle_cnt), 5);
    chk("mid.err", 32'(i0.err_cnt), 2);
    chk("mid.locked", 32'(i0.locked), 1);
    step(0, 1, 0, code_of(3));
    chk("rst.phase", 32'(i0.phase), 0);
    chk("rst.onehot", 32'(i0.phase_onehot), 0);
    chk("rst.valid", 32'(i0.valid), 0);
    chk("rst.locked", 32'(i0.locked), 0);
    chk("rst.err", 32'(i0.err_cnt), 0);
    chk("rst.cyc", 32'(i0.cycle_cnt), 0);

    // Random traffic against the behavioural model.
    cur = 0;
    for (int i = 0; i < 3000; i++) begin
      c   = ($urandom_range(199) != 0) ? 1 : 0;
      e   = ($urandom_range(9) != 0) ? 1 : 0;
      ec  = ($urandom_range(29) == 0) ? 1 : 0;
      sel = $urandom_range(99);
      if (sel < 70) begin
        cur  = (cur + 1) % 8;
        code = code_of(cur);
      end else if (sel < 78) begin
        code = code_of(cur);
      end else if (sel < 88) begin
        cur  = $urandom_range(7);
        code = code_of(cur);
      end else begin
        code = ILL[$urandom_range(7)];
      end
      step(c, e, ec, code);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/johnson_seq_checker.md
Name: johnson_seq_checker

Overview:
- Downstream consumer of the 4-bit Johnson counter FSM output.
- Decodes the 8 legal Johnson codes into a phase index and a one-hot word.
- Verifies that successive samples follow the Johnson sequence, and reports lock status, sequence errors and full-cycle completions.
- Sits between the counter and any phase-driven logic, e.g. LED sequencers or stepper drivers.

Parameters:
- LOCK_N, 3: consecutive correct transitions required to enter LOCKED (legal range 1..15).
- ALLOW_HOLD, 0: 1 = a repeated legal code is neutral; 0 = a repeated legal code is a wrong step.
- ERR_W, 8: width of the error counter.
- CYC_W, 8: width of the full-cycle counter.

Ports:
- clk  in  1  rising-edge clock, shared with the counter.
- clear  in  1  synchronous, active-low reset.
- count_in  in  4  Johnson code from the upstream counter.
- en  in  1  sample enable; when 0, all state and outputs hold.
- err_clr  in  1  synchronous clear of err_cnt.
- phase  out  3  decoded index of the last legal sample.
- phase_onehot  out  8  bit[phase] set when valid=1; all zero when valid=0.
- valid  out  1  last sample was a legal code.
- locked  out  1  FSM is in LOCKED.
- seq_err  out  1  one-cycle pulse on an error detected while LOCKED.
- err_cnt  out  ERR_W  saturating error count.
- wrap  out  1  one-cycle pulse on a locked 7->0 step.
- cycle_cnt  out  CYC_W  wrapping count of wrap pulses.

Behaviour:
- Decode table:
  - 0000->0, 1000->1, 1100->2, 1110->3
  - 1111->4, 0111->5, 0011->6, 0001->7
  - The other 8 codes are illegal.
- All outputs are registered. Latency is 1 clk from the sampled edge (en=1) to the updated outputs.
- Reset (clear=0 at a rising edge, regardless of en or err_clr):
  - phase=0, phase_onehot=0, valid=0, locked=0, seq_err=0, err_cnt=0, wrap=0, cycle_cnt=0.
  - FSM state = UNLOCKED, run counter=0, previous-phase register=0.
  - Reset mid-operation discards lock and all counts.
- en=0: no state changes, seq_err and wrap forced to 0, err_clr still honoured.
- Legal sample: phase updates. Illegal sample: phase holds its last legal value, valid=0, onehot=0.
- Step classification (evaluated when en=1 and the previous sample was legal):
  - good: cur = (prev+1) mod 8.
  - hold: cur = prev and ALLOW_HOLD=1.
  - bad: anything else, including an illegal current sample.
- FSM states:
  - UNLOCKED:
    - legal sample -> ACQUIRE, run=0 (the sample anchors prev).
    - illegal sample -> stay.
  - ACQUIRE:
    - good -> run+1; if run+1 = LOCK_N -> LOCKED.
    - hold -> no change.
    - bad with legal cur -> stay, run=0, re-anchor on cur.
    - illegal -> UNLOCKED.
  - LOCKED:
    - good or hold -> stay.
    - bad -> seq_err=1 for 1 clk and err_cnt+1; then legal cur -> ACQUIRE (run=0) or illegal -> UNLOCKED.
- With LOCK_N=1, the first good step locks.
- Bad steps in UNLOCKED or ACQUIRE never assert seq_err or change err_cnt.
- err_cnt:
  - Saturates at 2^ERR_W-1.
  - err_clr=1 zeroes it; clear wins over a simultaneous increment (the result is 0).
- wrap / cycle_cnt:
  - Only in LOCKED (including the cycle that enters LOCKED), on a good 7->0 step: wrap=1 for 1 clk, cycle_cnt+1.
  - cycle_cnt wraps from 2^CYC_W-1 to 0.
- locked is asserted on the cycle after the transition into LOCKED and deasserted on the cycle after the bad step, concurrent with seq_err.

Test Plan:
- Lock and wrap: clear pulse, then en=1, driving 0000,1000,1100,1110 -> valid=1 from the 1st output; locked=1 after the 3rd good step (sample 1110); phase 0,1,2,3 with onehot 01,02,04,08. Continue through 0001->0000 -> wrap=1 once, cycle_cnt=1.
- Locked skip error: in lock at phase 2 (1100), drive 1111 -> seq_err=1 for 1 clk, err_cnt=1, locked=0, FSM=ACQUIRE anchored at phase 4. Three further good steps -> relocked.
- Illegal code: in lock, drive 1010 -> valid=0, onehot=00, phase holds 2, seq_err=1, FSM=UNLOCKED. Next 0000 -> ACQUIRE.
- Hold handling: ALLOW_HOLD=0, locked, repeat 1110 -> seq_err=1. Rerun with ALLOW_HOLD=1 -> locked stays 1, err_cnt unchanged.
- Saturation, clear priority and en: ERR_W=2, force 5 locked errors -> err_cnt stops at 3. err_clr with a simultaneous error -> err_cnt=0. en=0 while count_in changes -> outputs frozen.
- Reset mid-run: clear=0 while locked, cycle_cnt=5, err_cnt=2 -> next edge all outputs 0, locked=0; clear=0 with en=1 and a legal code -> reset wins.
